parallel_reduce_accumulator: RTL and testbench



---
 rtl/accum_pkg.sv | 44 ++++
 rtl/accum_lane.sv | 47 ++++
 rtl/parallel_reduce_accumulator.sv | 169 ++++++++++++++++
 tb/tb_parallel_reduce_accumulator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and helpers for parallel_reduce_accumulator.
//   state_t   : controller states
//   add_res_t : sum plus carry-out from sat_add
//   cnt_w()   : width needed to hold a count of 0..depth
//   sat_add() : width-limited add with optional unsigned saturation
package accum_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Widest operand the adder helper supports.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic             carry;
    logic [MAX_W-1:0] sum;
  } add_res_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Adds the low w bits of a and b. carry is the bit just above the
  // operand width; on carry with sat set the sum pins to all-ones.
  function automatic add_res_t sat_add(input logic [MAX_W-1:0] a,
                                       input logic [MAX_W-1:0] b,
                                       input int unsigned      w,
                                       input bit               sat);
    add_res_t         res;
    logic [MAX_W:0]   full;
    logic [MAX_W-1:0] mask;
    mask      = '1;
    mask      = mask >> (MAX_W - w);
    full      = {1'b0, a & mask} + {1'b0, b & mask};
    res.carry = full[w[6:0]];
    res.sum   = (sat && res.carry) ? mask : (full[MAX_W-1:0] & mask);
    return res;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One registered adder lane.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : a/b hold a popped pair this cycle
//   a, b       : operands
//   out_valid  : sum/carry hold a result (one cycle after in_valid)
//   sum, carry : registered sum and carry-out
module accum_lane
  import accum_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  add_res_t w_add;

  assign w_add = sat_add(MAX_W'(a), MAX_W'(b), DATA_W, SATURATE);

  // Upper bits of the helper result are always zero for this width.
  if (DATA_W < MAX_W) begin : g_pad
    logic w_unused_hi;
    assign w_unused_hi = ^w_add.sum[MAX_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= w_add.sum[DATA_W-1:0];
        carry <= w_add.carry;
      end
    end
  end

endmodule

// File: rtl/parallel_reduce_accumulator.sv
// Loads unsigned words into a pool, then reduces the pool to one sum with
// NUM_LANES pipelined adder lanes.
//   clk, reset                      : clock, synchronous active-high reset
//   load_valid/data/last, load_ready: operand load handshake
//   clear                           : leave DONE for IDLE
//   result, result_valid            : final sum, high throughout DONE
//   overflow                        : sticky lane carry-out for this job
//   cycle_count                     : REDUCE cycles for this job (saturating)
//
// state  | meaning
// IDLE   | empty pool, waiting for first word
// LOAD   | words arriving, load_last not yet seen
// REDUCE | popping pairs into lanes, pushing lane sums back
// DONE   | pool[0] holds the sum, waiting for clear
module parallel_reduce_accumulator
  import accum_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int NUM_LANES = 4,
  parameter int SATURATE  = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              clear,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              overflow,
  output logic [CNT_W-1:0]  cycle_count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             r_state, w_state_next;
  logic [CW-1:0]      r_count, w_count_next;
  logic [DATA_W-1:0]  r_pool [DEPTH];
  logic [DATA_W-1:0]  r_result;
  logic               r_overflow;
  logic [CNT_W-1:0]   r_cycle_count;

  logic               w_load_fire;
  logic               w_exit;
  logic               w_carry_any;

  logic [NUM_LANES-1:0] w_lane_in_valid;
  logic [NUM_LANES-1:0] w_lane_valid;
  logic [NUM_LANES-1:0] w_lane_carry;
  logic [DATA_W-1:0]    w_lane_a   [NUM_LANES];
  logic [DATA_W-1:0]    w_lane_b   [NUM_LANES];
  logic [DATA_W-1:0]    w_lane_sum [NUM_LANES];
  logic [AW-1:0]        w_push_idx [NUM_LANES];

  assign load_ready  = ((r_state == IDLE) || (r_state == LOAD)) &&
                       (r_count < CW'(DEPTH));
  assign w_load_fire = load_valid && load_ready;

  // Pops come from the top of the pool; last cycle's lane sums land just
  // above what remains after this cycle's pops, so the two never overlap.
  always_comb begin
    int c, p, v;
    c = int'(r_count);
    p = c / 2;
    if (p > NUM_LANES) p = NUM_LANES;
    v = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_lane_valid[i]) v = v + 1;
    end
    w_exit       = (c == 1) && (v == 0);
    w_count_next = CW'(c - 2 * p + v);
    w_carry_any  = |(w_lane_valid & w_lane_carry);
    for (int i = 0; i < NUM_LANES; i++) begin
      w_lane_in_valid[i] = 1'b0;
      w_lane_a[i]        = '0;
      w_lane_b[i]        = '0;
      w_push_idx[i]      = AW'(c - 2 * p + i);
      if ((r_state == REDUCE) && (i < p)) begin
        w_lane_in_valid[i] = 1'b1;
        w_lane_a[i]        = r_pool[AW'(c - 1 - 2 * i)];
        w_lane_b[i]        = r_pool[AW'(c - 2 - 2 * i)];
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    accum_lane #(
      .DATA_W   (DATA_W),
      .SATURATE (SATURATE != 0)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (w_lane_in_valid[g]),
      .a         (w_lane_a[g]),
      .b         (w_lane_b[g]),
      .out_valid (w_lane_valid[g]),
      .sum       (w_lane_sum[g]),
      .carry     (w_lane_carry[g])
    );
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, LOAD: begin
        if (w_load_fire) w_state_next = load_last ? REDUCE : LOAD;
      end
      REDUCE: begin
        if (w_exit) w_state_next = DONE;
      end
      DONE: begin
        if (clear) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_result      <= '0;
      r_overflow    <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE, LOAD: begin
          if (w_load_fire) r_count <= r_count + 1'b1;
        end
        REDUCE: begin
          r_count <= w_count_next;
          if (w_carry_any) r_overflow <= 1'b1;
          if (r_cycle_count != '1) r_cycle_count <= r_cycle_count + 1'b1;
          if (w_exit) r_result <= r_pool[0];
        end
        DONE: begin
          if (clear) begin
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_cycle_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Pool storage needs no reset; lanes are cleared by reset so no stale push
  // can follow an abort.
  always_ff @(posedge clk) begin
    if (w_load_fire) r_pool[AW'(r_count)] <= load_data;
    if (r_state == REDUCE) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (w_lane_valid[i]) r_pool[w_push_idx[i]] <= w_lane_sum[i];
      end
    end
  end

  assign result       = r_result;
  assign result_valid = (r_state == DONE);
  assign overflow     = r_overflow;
  assign cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_parallel_reduce_accumulator.sv
module tb_parallel_reduce_accumulator;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int LANES = 4;
  localparam int CNTW  = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            load_valid;
  logic [DW-1:0]   load_data;
  logic            load_last;
  logic            clear;

  logic            load_ready, load_ready_s;
  logic [DW-1:0]   result, result_s;
  logic            result_valid, result_valid_s;
  logic            overflow, overflow_s;
  logic [CNTW-1:0] cycle_count, cycle_count_s;

  always #5 clk = ~clk;

  parallel_reduce_accumulator #(
    .DATA_W(DW), .DEPTH(DEPTH), .NUM_LANES(LANES), .SATURATE(0), .CNT_W(CNTW)
  ) u_dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready), .clear(clear),
    .result(result), .result_valid(result_valid), .overflow(overflow),
    .cycle_count(cycle_count)
  );

  parallel_reduce_accumulator #(
    .DATA_W(DW), .DEPTH(DEPTH), .NUM_LANES(LANES), .SATURATE(1), .CNT_W(CNTW)
  ) u_dut_sat (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready_s), .clear(clear),
    .result(result_s), .result_valid(result_valid_s), .overflow(overflow_s),
    .cycle_count(cycle_count_s)
  );

  typedef struct {
    logic [DW-1:0]   res_wrap;
    logic [DW-1:0]   res_sat;
    logic            ovf;
    logic [CNTW-1:0] cycles;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] words[$];
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Count sequence of the reduction: pop min(LANES, c/2) pairs, results
  // return one cycle later, exit when one word is left and no lane is busy.
  function automatic int model_cycles(input int n);
    int c, v, p, cyc;
    c = n; v = 0; cyc = 0;
    for (int k = 0; k < 1000; k++) begin
      cyc++;
      if (c == 1 && v == 0) break;
      p = c / 2;
      if (p > LANES) p = LANES;
      c = c - 2 * p + v;
      v = p;
    end
    return cyc;
  endfunction

  task automatic push_expect();
    logic [63:0] total;
    exp_t e;
    total = 0;
    foreach (words[i]) total = total + 64'(words[i]);
    e.ovf      = (total >= 64'h1_0000_0000);
    e.res_wrap = total[DW-1:0];
    e.res_sat  = e.ovf ? '1 : total[DW-1:0];
    e.cycles   = CNTW'(model_cycles(words.size()));
    sb.push_back(e);
  endtask

  task automatic drive_words(input bit with_last);
    foreach (words[i]) begin
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = with_last && (i == words.size() - 1);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Full job: expectation queued at stimulus time, compared when DONE shows.
  task automatic run_job(input string tag, input bit pulse);
    int   lat;
    bit   seen;
    exp_t e;
    push_expect();
    drive_words(1'b1);
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (pulse) begin
        load_valid = k[0];
        load_data  = 32'h0000_1000;
      end
      @(negedge clk);
      lat++;
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      if (pulse) check({tag, " ready_in_reduce"}, load_ready, 1'b0);
    end
    load_valid = 1'b0;
    check({tag, " done_seen"}, seen, 1'b1);
    e = sb.pop_front();
    check({tag, " latency"}, lat, e.cycles);
    check({tag, " result"}, result, e.res_wrap);
    check({tag, " overflow"}, overflow, e.ovf);
    check({tag, " cycle_count"}, cycle_count, e.cycles);
    check({tag, " sat_valid"}, result_valid_s, 1'b1);
    check({tag, " sat_result"}, result_s, e.res_sat);
    check({tag, " sat_overflow"}, overflow_s, e.ovf);
    @(negedge clk);
    check({tag, " result_stable"}, result, e.res_wrap);
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check({tag, " valid_after_clear"}, result_valid, 1'b0);
    check({tag, " ready_after_clear"}, load_ready, 1'b1);
    check({tag, " ovf_after_clear"}, overflow, 1'b0);
    check({tag, " cc_after_clear"}, cycle_count, 16'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0; clear = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst result", result, 32'd0);
    check("rst result_valid", result_valid, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst cycle_count", cycle_count, 16'd0);
    check("rst load_ready", load_ready, 1'b1);

    // 1..8 -> 36
    words = {};
    for (int i = 1; i <= 8; i++) words.push_back(32'(i));
    run_job("sum8", 1'b0);
    check("sum8 const_result", result, 32'd36);
    check("sum8 const_cycles", cycle_count, 16'd7);
    do_clear("sum8");

    // single word
    words = {32'hDEAD_BEEF};
    run_job("one", 1'b0);
    check("one const_cycles", cycle_count, 16'd1);
    do_clear("one");

    // carry-out: wrap vs saturate
    words = {32'hFFFF_FFFF, 32'h0000_0002};
    run_job("ovf", 1'b0);
    check("ovf const_wrap", result, 32'h0000_0001);
    check("ovf const_sat", result_s, 32'hFFFF_FFFF);
    do_clear("ovf");

    // fill to DEPTH without load_last: stall
    words = {};
    for (int i = 0; i < DEPTH; i++) words.push_back(32'(100 + i));
    drive_words(1'b0);
    check("fill ready_low", load_ready, 1'b0);
    load_valid = 1'b1; load_data = 32'h55; load_last = 1'b1;
    repeat (3) @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    check("fill still_ready_low", load_ready, 1'b0);
    check("fill no_done", result_valid, 1'b0);
    check("fill cc_zero", cycle_count, 16'd0);
    do_reset();
    check("fill ready_after_reset", load_ready, 1'b1);
    check("fill valid_after_reset", result_valid, 1'b0);

    // abort an 8-word reduce in its third cycle
    words = {};
    for (int i = 0; i < 8; i++) words.push_back(32'hF000_0000 + 32'(i));
    drive_words(1'b1);
    repeat (2) @(negedge clk);
    check("abort in_reduce_ready", load_ready, 1'b0);
    do_reset();
    check("abort ready", load_ready, 1'b1);
    check("abort valid", result_valid, 1'b0);
    check("abort overflow", overflow, 1'b0);
    check("abort cycle_count", cycle_count, 16'd0);
    check("abort result", result, 32'd0);
    words = {32'd5, 32'd6, 32'd7};
    run_job("after_abort", 1'b0);
    check("after_abort const_result", result, 32'd18);
    check("after_abort const_cycles", cycle_count, 16'd5);
    do_clear("after_abort");

    // five ones with load_valid pulses during REDUCE
    words = {32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    run_job("five", 1'b1);
    check("five const_result", result, 32'd5);
    check("five const_cycles", cycle_count, 16'd7);
    do_clear("five");

    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
